// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC frame filter on an 8-bit RX AXI-Stream: holds the 6 DA bytes, decides pass/drop, replays DA, then streams.
// Latency: first DA byte on m_axis one cycle after the 6th byte is accepted; payload is combinational (+0) once passing.
// Backpressure: upstream is stalled during the 6-byte replay; in pass-through s_axis_tready follows m_axis_tready.
//
// Ports:
//   clock, resetn                  single clock, synchronous active-low reset
//   s_axis_* (tdata/tkeep/tvalid/tready/tlast/tuser)   RX bytes from the MAC (tkeep ignored)
//   m_axis_* (tdata/tkeep/tvalid/tready/tlast/tuser)   filtered bytes to the DMA (tkeep constant 1)
//   mac_addr, promisc_en, bcast_en, mcast_en           filter configuration, sampled on the decision cycle
//   frames_passed, frames_dropped  statistics counters
//
// Optional feature: define ETH_RX_FILTER_STATS_EN to build the statistics counters.
// Without it both counter outputs are tied to zero and filtering is unchanged.

module eth_rx_mac_filter #(
   parameter int COUNTER_WIDTH = 32,
   parameter int SATURATE      = 0
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [7:0]               s_axis_tdata,
   input  logic                     s_axis_tkeep,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tlast,
   input  logic                     s_axis_tuser,
   output logic [7:0]               m_axis_tdata,
   output logic                     m_axis_tkeep,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tuser,
   input  logic [47:0]              mac_addr,
   input  logic                     promisc_en,
   input  logic                     bcast_en,
   input  logic                     mcast_en,
   output logic [COUNTER_WIDTH-1:0] frames_passed,
   output logic [COUNTER_WIDTH-1:0] frames_dropped
);

   localparam logic [1:0] ST_HDR    = 2'd0;
   localparam logic [1:0] ST_REPLAY = 2'd1;
   localparam logic [1:0] ST_PASS   = 2'd2;
   localparam logic [1:0] ST_DROP   = 2'd3;

   localparam logic [2:0] IDX_LAST  = 3'd5;

   logic [1:0]  state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  hdr_q [0:5];
   logic        hdr_we;
   logic [7:0]  m_tdata_q, m_tdata_d;
   logic        m_tvalid_q, m_tvalid_d;
   logic        inc_passed, inc_dropped;

   logic        s_hs, m_hs;
   logic        in_pass;
   logic [47:0] da;
   logic        ucast_hit, bcast_hit, mcast_hit, match;

   logic        unused_in;
   assign unused_in = s_axis_tkeep;

   assign in_pass = (state_q == ST_PASS);

   // ------------------------------------------------------------------
   // Stream outputs: registered replay path, combinational pass-through
   // ------------------------------------------------------------------
   always_comb begin
      s_axis_tready = 1'b0;
      if (resetn) begin
         case (state_q)
            ST_HDR,
            ST_DROP: s_axis_tready = 1'b1;
            ST_PASS: s_axis_tready = m_axis_tready;
            default: s_axis_tready = 1'b0;
         endcase
      end
   end

   // Valid is masked while resetn is low so the downstream side never
   // takes a byte the upstream side is not simultaneously giving up.
   assign m_axis_tvalid = resetn & (in_pass ? s_axis_tvalid : m_tvalid_q);
   assign m_axis_tdata  = in_pass ? s_axis_tdata : m_tdata_q;
   assign m_axis_tlast  = in_pass & s_axis_tlast;
   assign m_axis_tuser  = in_pass & s_axis_tlast & s_axis_tuser;
   assign m_axis_tkeep  = 1'b1;

   assign s_hs = s_axis_tvalid & s_axis_tready;
   assign m_hs = m_axis_tvalid & m_axis_tready;

   // ------------------------------------------------------------------
   // Address match. On the decision cycle the 6th DA byte is still on
   // the input bus, so it is taken from s_axis_tdata rather than hdr_q.
   // ------------------------------------------------------------------
   assign da        = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], s_axis_tdata};
   assign ucast_hit = (da == mac_addr);
   assign bcast_hit = bcast_en & (&da);
   // Group bit is the LSB of the first DA byte; broadcast also has it set.
   assign mcast_hit = mcast_en & hdr_q[0][0];
   assign match     = promisc_en | ucast_hit | bcast_hit | mcast_hit;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      m_tdata_d   = m_tdata_q;
      m_tvalid_d  = m_tvalid_q;
      hdr_we      = 1'b0;
      inc_passed  = 1'b0;
      inc_dropped = 1'b0;

      case (state_q)
         ST_HDR: begin
            if (s_hs) begin
               hdr_we = 1'b1;
               if (s_axis_tlast) begin
                  // Frame ended inside the DA (<= 6 bytes): runt.
                  inc_dropped = 1'b1;
                  idx_d       = 3'd0;
               end else if (idx_q == IDX_LAST) begin
                  idx_d = 3'd0;
                  if (match) begin
                     state_d    = ST_REPLAY;
                     m_tdata_d  = hdr_q[0];
                     m_tvalid_d = 1'b1;
                  end else begin
                     state_d    = ST_DROP;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         ST_REPLAY: begin
            // idx_q names the byte currently presented on m_axis_tdata.
            if (m_hs) begin
               if (idx_q == IDX_LAST) begin
                  state_d    = ST_PASS;
                  m_tvalid_d = 1'b0;
                  idx_d      = 3'd0;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  m_tdata_d = hdr_q[idx_q + 3'd1];
               end
            end
         end

         ST_PASS: begin
            if (s_hs && s_axis_tlast) begin
               inc_passed = 1'b1;
               state_d    = ST_HDR;
               idx_d      = 3'd0;
            end
         end

         ST_DROP: begin
            if (s_hs && s_axis_tlast) begin
               inc_dropped = 1'b1;
               state_d     = ST_HDR;
               idx_d       = 3'd0;
            end
         end

         default: begin
            state_d    = ST_HDR;
            idx_d      = 3'd0;
            m_tvalid_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= ST_HDR;
         idx_q      <= 3'd0;
         m_tdata_q  <= 8'd0;
         m_tvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
      end
   end

   // Header bytes carry no control meaning until the decision, so they
   // are left out of reset.
   always_ff @(posedge clock) begin
      if (hdr_we) begin
         hdr_q[idx_q] <= s_axis_tdata;
      end
   end

   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
`ifdef ETH_RX_FILTER_STATS_EN
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   logic [COUNTER_WIDTH-1:0] passed_q, passed_d;
   logic [COUNTER_WIDTH-1:0] dropped_q, dropped_d;

   function automatic logic [COUNTER_WIDTH-1:0] bump(input logic [COUNTER_WIDTH-1:0] v);
      if ((SATURATE != 0) && (v == CNT_MAX)) begin
         return v;
      end
      return v + CNT_ONE;
   endfunction

   always_comb begin
      passed_d  = passed_q;
      dropped_d = dropped_q;
      if (inc_passed) begin
         passed_d = bump(passed_q);
      end
      if (inc_dropped) begin
         dropped_d = bump(dropped_q);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         passed_q  <= '0;
         dropped_q <= '0;
      end else begin
         passed_q  <= passed_d;
         dropped_q <= dropped_d;
      end
   end

   assign frames_passed  = passed_q;
   assign frames_dropped = dropped_q;
`else
   logic unused_stats;
   assign unused_stats   = inc_passed ^ inc_dropped ^ (SATURATE != 0);
   assign frames_passed  = '0;
   assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed bench for eth_rx_mac_filter: unicast/broadcast/multicast/promiscuous filtering, runts,
// downstream backpressure, mid-frame reset and counter saturation on a second narrow instance.
// Each scenario task drives frames and compares the captured output stream and counters inline.

module tb_eth_rx_mac_filter;

`ifdef ETH_RX_FILTER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;

   logic        clock;
   logic        resetn;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tkeep;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic        s_axis_tuser;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tkeep;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [47:0] mac_addr;
   logic        promisc_en, bcast_en, mcast_en;
   logic [31:0] frames_passed, frames_dropped;

   logic        sat_s_tready;
   logic [7:0]  sat_m_tdata;
   logic        sat_m_tkeep, sat_m_tvalid, sat_m_tlast, sat_m_tuser;
   logic [1:0]  sat_passed, sat_dropped;

   eth_rx_mac_filter #(.COUNTER_WIDTH(32), .SATURATE(0)) dut (
      .clock(clock), .resetn(resetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .mac_addr(mac_addr), .promisc_en(promisc_en), .bcast_en(bcast_en), .mcast_en(mcast_en),
      .frames_passed(frames_passed), .frames_dropped(frames_dropped)
   );

   eth_rx_mac_filter #(.COUNTER_WIDTH(2), .SATURATE(1)) dut_sat (
      .clock(clock), .resetn(resetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(sat_s_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(sat_m_tdata), .m_axis_tkeep(sat_m_tkeep), .m_axis_tvalid(sat_m_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(sat_m_tlast), .m_axis_tuser(sat_m_tuser),
      .mac_addr(mac_addr), .promisc_en(promisc_en), .bcast_en(bcast_en), .mcast_en(mcast_en),
      .frames_passed(sat_passed), .frames_dropped(sat_dropped)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          stall_cyc = 0;
   int          acc6_cyc = 0;
   int          first_out_cyc = -1;
   int          stab_err = 0;
   int          sat_diff = 0;
   int          timeouts = 0;
   bit          bp_en    = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_dat;
   logic        prev_last;
   logic [7:0]  frame_q[$];
   logic [9:0]  rx_q[$];
   int unsigned exp_pass = 0;
   int unsigned exp_drop = 0;

   always @(posedge clock) cyc++;

   always @(posedge clock) begin
      #1;
      m_axis_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
   end

   // Output monitor: captures handshakes and watches AXIS hold rules.
   always @(negedge clock) begin
      if (resetn) begin
         if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_dat || m_axis_tlast !== prev_last))
            stab_err++;
         if (m_axis_tvalid && m_axis_tready) begin
            if (rx_q.size() == 0) first_out_cyc = cyc;
            rx_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
         end
         if ({sat_s_tready, sat_m_tvalid, sat_m_tdata, sat_m_tlast, sat_m_tuser, sat_m_tkeep} !==
             {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tkeep})
            sat_diff++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_dat   = m_axis_tdata;
         prev_last  = m_axis_tlast;
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic int unsigned cnt_exp(input int unsigned v);
      return STATS ? v : 0;
   endfunction

   task automatic build_frame(input logic [47:0] da, input int len, input int seed);
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
         if (i < 6) frame_q.push_back(da[47-8*i -: 8]);
         else       frame_q.push_back(8'((i * 13 + seed) & 255));
      end
   endtask

   // Sends the first nsend bytes of a len-byte frame; tlast only if the frame is sent whole.
   task automatic send_frame(input int len, input int nsend, input bit user);
      int guard;
      bit hs;
      for (int i = 0; i < nsend; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frame_q[i];
         s_axis_tlast  = (i == len - 1);
         s_axis_tuser  = user && (i == len - 1);
         guard = 0;
         hs    = 1'b0;
         while (!hs && guard < 200) begin
            @(negedge clock);
            hs = s_axis_tready;
            if (!hs) stall_cyc++;
            if (hs && i == 5) acc6_cyc = cyc;
            @(posedge clock); #1;
            guard++;
         end
         if (!hs) begin
            timeouts++;
            break;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_drain(input int n);
      int g = 0;
      while (rx_q.size() < n && g < 400) begin
         @(posedge clock); #1;
         g++;
      end
      if (rx_q.size() < n) timeouts++;
      repeat (4) @(posedge clock);
      #1;
   endtask

   task automatic count_errs(input int len, input bit user, output int errs);
      logic [9:0] e;
      errs = 0;
      for (int i = 0; i < len; i++) begin
         e = {user && (i == len - 1), (i == len - 1), frame_q[i]};
         if (i >= rx_q.size()) errs++;
         else if (rx_q[i] !== e) errs++;
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL reset_s_tready: got %b want 0", s_axis_tready); else n_pass++;
      n_checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0)
         $display("FAIL reset_m_outputs: got v%b l%b u%b d%h want all 0", m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
      else n_pass++;
      n_checks++; if (frames_passed !== 0 || frames_dropped !== 0)
         $display("FAIL reset_counters: got %0d/%0d want 0/0", frames_passed, frames_dropped); else n_pass++;
      @(posedge clock); #1;
      resetn = 1'b1;
      @(negedge clock);
      n_checks++; if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0)
         $display("FAIL idle_after_reset: got rdy%b vld%b want rdy1 vld0", s_axis_tready, m_axis_tvalid); else n_pass++;
      @(posedge clock); #1;
   endtask

   task automatic test_unicast_pass;
      int errs;
      rx_q.delete();
      build_frame(MY_MAC, 64, 1);
      send_frame(64, 64, 1'b0);
      wait_drain(64);
      exp_pass++;
      count_errs(64, 1'b0, errs);
      n_checks++; if (rx_q.size() !== 64) $display("FAIL ucast_len: got %0d want 64", rx_q.size()); else n_pass++;
      n_checks++; if (errs !== 0) $display("FAIL ucast_bytes: got %0d bad bytes want 0", errs); else n_pass++;
      n_checks++; if (first_out_cyc !== acc6_cyc + 1)
         $display("FAIL ucast_latency: got first out at cycle %0d want %0d", first_out_cyc, acc6_cyc + 1); else n_pass++;
      n_checks++; if (frames_passed !== cnt_exp(exp_pass))
         $display("FAIL ucast_passed_cnt: got %0d want %0d", frames_passed, cnt_exp(exp_pass)); else n_pass++;
   endtask

   task automatic test_unicast_drop;
      rx_q.delete();
      stall_cyc = 0;
      build_frame(48'h02_00_00_00_00_02, 64, 2);
      send_frame(64, 64, 1'b0);
      wait_drain(0);
      exp_drop++;
      n_checks++; if (rx_q.size() !== 0) $display("FAIL drop_output: got %0d bytes want 0", rx_q.size()); else n_pass++;
      n_checks++; if (stall_cyc !== 0) $display("FAIL drop_ready: got %0d stalled cycles want 0", stall_cyc); else n_pass++;
      n_checks++; if (frames_dropped !== cnt_exp(exp_drop))
         $display("FAIL drop_cnt: got %0d want %0d", frames_dropped, cnt_exp(exp_drop)); else n_pass++;
   endtask

   task automatic test_addr_classes;
      logic [47:0] da_tab [0:5];
      bit          pr_tab [0:5];
      bit          bc_tab [0:5];
      bit          mc_tab [0:5];
      bit          ok_tab [0:5];
      int          errs;
      da_tab = '{48'hFF_FF_FF_FF_FF_FF, 48'hFF_FF_FF_FF_FF_FF, 48'h01_00_5E_00_00_01,
                 48'h01_00_5E_00_00_01, 48'h12_34_56_78_9A_BC, 48'hFF_FF_FF_FF_FF_FF};
      pr_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      bc_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      mc_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      ok_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 6; k++) begin
         rx_q.delete();
         promisc_en = pr_tab[k];
         bcast_en   = bc_tab[k];
         mcast_en   = mc_tab[k];
         build_frame(da_tab[k], 16, 10 + k);
         send_frame(16, 16, 1'b0);
         wait_drain(ok_tab[k] ? 16 : 0);
         if (ok_tab[k]) exp_pass++; else exp_drop++;
         count_errs(16, 1'b0, errs);
         n_checks++;
         if (ok_tab[k] ? (errs !== 0 || rx_q.size() !== 16) : (rx_q.size() !== 0))
            $display("FAIL class_%0d: got %0d bytes (%0d bad) want %0d bytes", k, rx_q.size(), errs, ok_tab[k] ? 16 : 0);
         else n_pass++;
      end
      promisc_en = 1'b0; bcast_en = 1'b0; mcast_en = 1'b0;
      n_checks++; if (frames_passed !== cnt_exp(exp_pass) || frames_dropped !== cnt_exp(exp_drop))
         $display("FAIL class_cnt: got %0d/%0d want %0d/%0d", frames_passed, frames_dropped, cnt_exp(exp_pass), cnt_exp(exp_drop));
      else n_pass++;
   endtask

   task automatic test_runt;
      int errs;
      rx_q.delete();
      build_frame(MY_MAC, 6, 20);
      send_frame(6, 6, 1'b0);
      build_frame(MY_MAC, 3, 21);
      send_frame(3, 3, 1'b0);
      wait_drain(0);
      exp_drop += 2;
      n_checks++; if (rx_q.size() !== 0) $display("FAIL runt_output: got %0d bytes want 0", rx_q.size()); else n_pass++;
      n_checks++; if (frames_dropped !== cnt_exp(exp_drop))
         $display("FAIL runt_cnt: got %0d want %0d", frames_dropped, cnt_exp(exp_drop)); else n_pass++;
      build_frame(MY_MAC, 64, 22);
      send_frame(64, 64, 1'b0);
      wait_drain(64);
      exp_pass++;
      count_errs(64, 1'b0, errs);
      n_checks++; if (errs !== 0 || rx_q.size() !== 64)
         $display("FAIL after_runt: got %0d bytes (%0d bad) want 64", rx_q.size(), errs); else n_pass++;
   endtask

   task automatic test_backpressure;
      int errs;
      bp_en    = 1'b1;
      stab_err = 0;
      rx_q.delete();
      build_frame(MY_MAC, 64, 30);
      send_frame(64, 64, 1'b1);
      wait_drain(64);
      exp_pass++;
      count_errs(64, 1'b1, errs);
      n_checks++; if (errs !== 0 || rx_q.size() !== 64)
         $display("FAIL bp_bytes: got %0d bytes (%0d bad) want 64", rx_q.size(), errs); else n_pass++;
      n_checks++; if (rx_q.size() > 0 && rx_q[rx_q.size()-1][9:8] !== 2'b11)
         $display("FAIL bp_tuser_last: got user/last %b want 11", rx_q[rx_q.size()-1][9:8]); else n_pass++;
      rx_q.delete();
      build_frame(MY_MAC, 30, 31);
      send_frame(30, 30, 1'b0);
      wait_drain(30);
      exp_pass++;
      count_errs(30, 1'b0, errs);
      n_checks++; if (errs !== 0 || rx_q.size() !== 30)
         $display("FAIL bp_bytes2: got %0d bytes (%0d bad) want 30", rx_q.size(), errs); else n_pass++;
      n_checks++; if (stab_err !== 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); else n_pass++;
      bp_en = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset_midframe;
      int errs;
      build_frame(MY_MAC, 64, 40);
      send_frame(64, 20, 1'b0);
      resetn = 1'b0;
      @(posedge clock); #1;
      resetn = 1'b1;
      @(negedge clock);
      n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL mid_reset_vld: got %b want 0", m_axis_tvalid); else n_pass++;
      n_checks++; if (frames_passed !== 0 || frames_dropped !== 0 || sat_passed !== 0 || sat_dropped !== 0)
         $display("FAIL mid_reset_cnt: got %0d/%0d %0d/%0d want zeros", frames_passed, frames_dropped, sat_passed, sat_dropped);
      else n_pass++;
      exp_pass = 0;
      exp_drop = 0;
      @(posedge clock); #1;
      rx_q.delete();
      build_frame(MY_MAC, 64, 41);
      send_frame(64, 64, 1'b0);
      wait_drain(64);
      exp_pass++;
      count_errs(64, 1'b0, errs);
      n_checks++; if (errs !== 0 || rx_q.size() !== 64)
         $display("FAIL post_reset_frame: got %0d bytes (%0d bad) want 64", rx_q.size(), errs); else n_pass++;
   endtask

   task automatic test_saturate;
      sat_diff = 0;
      for (int k = 0; k < 4; k++) begin
         rx_q.delete();
         build_frame(MY_MAC, 10, 50 + k);
         send_frame(10, 10, 1'b0);
         wait_drain(10);
         exp_pass++;
      end
      n_checks++; if (sat_passed !== (STATS ? 2'd3 : 2'd0))
         $display("FAIL sat_passed: got %0d want %0d", sat_passed, STATS ? 3 : 0); else n_pass++;
      n_checks++; if (frames_passed !== cnt_exp(exp_pass))
         $display("FAIL wide_passed: got %0d want %0d", frames_passed, cnt_exp(exp_pass)); else n_pass++;
      n_checks++; if (sat_diff !== 0) $display("FAIL sat_stream_diff: got %0d differing cycles want 0", sat_diff); else n_pass++;
   endtask

   task automatic test_no_timeouts;
      n_checks++; if (timeouts !== 0) $display("FAIL timeouts: got %0d expired waits want 0", timeouts); else n_pass++;
   endtask

   initial begin
      resetn        = 1'b0;
      s_axis_tdata  = 8'd0;
      s_axis_tkeep  = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      m_axis_tready = 1'b1;
      mac_addr      = MY_MAC;
      promisc_en    = 1'b0;
      bcast_en      = 1'b0;
      mcast_en      = 1'b0;
      @(posedge clock); #1;
      test_reset;
      test_unicast_pass;
      test_unicast_drop;
      test_addr_classes;
      test_runt;
      test_backpressure;
      test_reset_midframe;
      test_saturate;
      test_no_timeouts;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
